// File: rtl/hazard_scoreboard.sv
// Decode-stage stall generator: tracks in-flight {dst, Tnew} writes plus the HI/LO busy counter.
// Optional EPC_HAZARD_EN: stall eret while an mtc0 to EPC is still in a tracked stage.
module hazard_scoreboard #(
    parameter int NSTAGE      = 2,
    parameter int TW          = 2,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D_valid,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic [TW-1:0] D_tuse_rs,
    input  logic [TW-1:0] D_tuse_rt,
    input  logic [4:0]    D_dst,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_hilo,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          D_eret,
    input  logic          D_mtc0_epc,
    input  logic          flush,
    output logic          stall,
    output logic          md_busy,
    output logic [3:0]    stall_cause
);
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef struct packed {
        logic          v;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
    } entry_t;

    entry_t [NSTAGE-1:0] ent;
    logic   [CW-1:0]     md_cnt;
    logic   [NSTAGE-1:0] hit_rs, hit_rt;
    logic                issue;

    assign issue = D_valid & ~stall & ~flush;

    // Tnew counts down as the entry ages, so a producer stops matching once its result is forwardable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent <= '0;
        end else if (flush) begin
            ent <= '0;
        end else begin
            ent[0] <= issue ? {1'b1, D_dst, D_tnew} : '0;
            for (int i = 1; i < NSTAGE; i++) begin
                ent[i].v    <= ent[i-1].v;
                ent[i].dst  <= ent[i-1].dst;
                ent[i].tnew <= (ent[i-1].tnew != '0) ? ent[i-1].tnew - T_ONE : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            md_cnt <= '0;
        else if (issue && D_md_start)
            md_cnt <= D_md_div ? DIV_LD : MULT_LD;
        else if (md_cnt != '0)
            md_cnt <= md_cnt - CNT_ONE;
    end

    for (genvar i = 0; i < NSTAGE; i++) begin : g_cmp
        assign hit_rs[i] = ent[i].v && (ent[i].dst != 5'd0) && (ent[i].dst == D_rs)
                           && (ent[i].tnew > D_tuse_rs);
        assign hit_rt[i] = ent[i].v && (ent[i].dst != 5'd0) && (ent[i].dst == D_rt)
                           && (ent[i].tnew > D_tuse_rt);
    end

    assign md_busy        = (md_cnt != '0);
    assign stall_cause[0] = D_valid & (|hit_rs);
    assign stall_cause[1] = D_valid & (|hit_rt);
    assign stall_cause[2] = D_valid & D_hilo & md_busy;

`ifdef EPC_HAZARD_EN
    logic [NSTAGE-1:0] epc;
    logic [NSTAGE-1:0] epc_live;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc <= '0;
        end else if (flush) begin
            epc <= '0;
        end else begin
            epc[0] <= issue & D_mtc0_epc;
            for (int i = 1; i < NSTAGE; i++)
                epc[i] <= epc[i-1];
        end
    end

    for (genvar i = 0; i < NSTAGE; i++) begin : g_epc
        assign epc_live[i] = ent[i].v & epc[i];
    end

    assign stall_cause[3] = D_valid & D_eret & (|epc_live);
`else
    logic unused_epc_inputs;
    assign unused_epc_inputs = D_eret ^ D_mtc0_epc;
    assign stall_cause[3]    = 1'b0;
`endif

    assign stall = |stall_cause;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed checks of hazard_scoreboard against a cycle-count reference model.
module tb_hazard_scoreboard;
    localparam int NSTAGE = 2;
`ifdef EPC_HAZARD_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       D_valid, D_hilo, D_md_start, D_md_div, D_eret, D_mtc0_epc, flush;
    logic [4:0] D_rs, D_rt, D_dst;
    logic [1:0] D_tuse_rs, D_tuse_rt, D_tnew;
    logic       stall, md_busy;
    logic [3:0] stall_cause;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
        .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt), .D_dst(D_dst), .D_tnew(D_tnew),
        .D_hilo(D_hilo), .D_md_start(D_md_start), .D_md_div(D_md_div), .D_eret(D_eret),
        .D_mtc0_epc(D_mtc0_epc), .flush(flush), .stall(stall), .md_busy(md_busy),
        .stall_cause(stall_cause)
    );

    always #5 clk = ~clk;

    // Reference model: issued instructions stamped with their issue cycle.
    typedef struct {
        int       icyc;
        int       tnew;
        logic [4:0] dst;
        bit       epc;
    } rec_t;

    rec_t recs[$];
    int   cyc      = 0;
    int   kill_cyc = -1;
    int   md_icyc  = 0;
    int   md_lat   = 0;
    int   n_vec    = 0;
    int   n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit model_busy();
        return (md_lat > 0) && (cyc > md_icyc) && (cyc <= md_icyc + md_lat);
    endfunction

    function automatic logic [3:0] model_cause();
        logic [3:0] c = '0;
        foreach (recs[k]) begin
            int age = cyc - recs[k].icyc;
            int rem;
            if (age < 1 || age > NSTAGE || recs[k].icyc <= kill_cyc) continue;
            rem = recs[k].tnew - (age - 1);
            if (rem < 0) rem = 0;
            if (recs[k].dst != 0 && recs[k].dst == D_rs && rem > int'(D_tuse_rs)) c[0] = 1'b1;
            if (recs[k].dst != 0 && recs[k].dst == D_rt && rem > int'(D_tuse_rt)) c[1] = 1'b1;
            if (EPC_EN && recs[k].epc && D_eret) c[3] = 1'b1;
        end
        if (D_hilo && model_busy()) c[2] = 1'b1;
        if (!D_valid) c = '0;
        return c;
    endfunction

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [1:0] tus,
                         input logic [4:0] rt, input logic [1:0] tut, input logic [4:0] dst,
                         input logic [1:0] tn, input logic hl, input logic ms, input logic md,
                         input logic er, input logic ep);
        D_valid = v; D_rs = rs; D_tuse_rs = tus; D_rt = rt; D_tuse_rt = tut;
        D_dst = dst; D_tnew = tn; D_hilo = hl; D_md_start = ms; D_md_div = md;
        D_eret = er; D_mtc0_epc = ep;
    endtask

    task automatic idle();
        set_d(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One cycle: compare at #1 after the falling edge, then advance the model at the rising edge.
    task automatic step(input int exp_c);
        logic [3:0] ec;
        bit         iss;
        #1;
        ec = model_cause();
        chk("stall", stall, |ec);
        chk("stall_cause", stall_cause, ec);
        chk("md_busy", md_busy, model_busy());
        if (exp_c >= 0) chk("directed_cause", stall_cause, exp_c);
        iss = D_valid && (ec == 4'd0) && !flush;
        @(posedge clk);
        if (flush) kill_cyc = cyc;
        if (iss) begin
            recs.push_back('{icyc: cyc, tnew: int'(D_tnew), dst: D_dst, epc: D_mtc0_epc});
            if (D_md_start) begin
                md_icyc = cyc;
                md_lat  = D_md_div ? 10 : 5;
            end
        end
        while (recs.size() > 0 && cyc - recs[0].icyc >= NSTAGE) void'(recs.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        idle();
        flush = 1'b0;
        #2;
        chk("reset_stall", stall, 1'b0);
        chk("reset_busy", md_busy, 1'b0);
        chk("reset_cause", stall_cause, 4'd0);
        @(negedge clk);
        reset = 1'b0;

        // load-use
        set_d(1, 0, 3, 0, 3, 2, 2, 0, 0, 0, 0, 0); step(0);
        set_d(1, 2, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0); step(4'b0001); step(0);
        idle(); step(0); step(0);
        // branch on a one-cycle producer
        set_d(1, 0, 3, 0, 3, 3, 1, 0, 0, 0, 0, 0); step(0);
        set_d(1, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0); step(4'b0010); step(0);
        idle(); step(0); step(0);
        // $zero never matches
        set_d(1, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0); step(0);
        set_d(1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0); step(0);
        idle(); step(0); step(0);
        // mult then mflo, div then mflo
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 1, 0, 0, 0); step(0);
        set_d(1, 0, 3, 0, 3, 7, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(4'b0100);
        step(0);
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0); step(0);
        set_d(1, 0, 3, 0, 3, 7, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(4'b0100);
        step(0);
        idle(); step(0); step(0);
        // flush after issue, then flush with simultaneous issue
        set_d(1, 0, 3, 0, 3, 5, 2, 0, 0, 0, 0, 0); step(0);
        idle(); flush = 1'b1; step(0); flush = 1'b0;
        set_d(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0); step(0);
        set_d(1, 0, 3, 0, 3, 5, 2, 0, 0, 0, 0, 0); flush = 1'b1; step(0); flush = 1'b0;
        set_d(1, 5, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0); step(0);
        idle(); step(0); step(0);
        // mtc0 EPC followed by eret
        set_d(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 1); step(0);
        set_d(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 0);
        step(EPC_EN ? 4'b1000 : 0); step(EPC_EN ? 4'b1000 : 0); step(0);
        idle(); step(0);

        // asynchronous reset while an MD operation is running
        set_d(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0); step(0);
        set_d(1, 0, 3, 0, 3, 7, 1, 1, 0, 0, 0, 0);
        #1;
        chk("pre_reset_busy", md_busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_reset_busy", md_busy, 1'b0);
        chk("async_reset_stall", stall, 1'b0);
        reset = 1'b0;
        recs.delete();
        md_lat = 0;
        @(negedge clk);
        cyc++;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic ms;
            ms = ($urandom_range(0, 9) == 0);
            set_d($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 2'($urandom),
                  5'($urandom_range(0, 3)), 2'($urandom), 5'($urandom_range(0, 3)), 2'($urandom),
                  ms | ($urandom_range(0, 5) == 0), ms, 1'($urandom),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 11) == 0);
            step(-1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
